// File: rtl/boot_copy_ctl.sv
// rtl/boot_copy_ctl.sv - boot ROM page to RAM copy sequencer holding the CPU until done
// Optional checksum gate on CPU release: define BOOTCOPY_CHECKSUM_EN.
module boot_copy_ctl #(
  parameter logic [14:0] SRC_BASE = 15'o07400,
  parameter logic [14:0] DST_BASE = 15'o07400,
  parameter logic [7:0]  COUNT    = 8'd128,
  parameter logic [11:0] START_PC = 12'o7400,
  parameter logic [11:0] CHECKSUM = 12'o0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [14:0] rom_addr,
  output logic        rom_rd,
  input  logic [11:0] rom_data,
  output logic [14:0] ram_addr,
  output logic [11:0] ram_wdata,
  output logic        ram_wr,
  input  logic        ram_ack,
  output logic        cpu_hold,
  output logic [11:0] start_pc,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, FINISH, DONE} state_t;

  state_t     state;
  logic [7:0] idx;
  logic [7:0] idx_next;

  assign idx_next = idx + 8'd1;

`ifdef BOOTCOPY_CHECKSUM_EN
  logic [11:0] sum;
`else
  logic unused_checksum;
  assign unused_checksum = ^CHECKSUM;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 8'd0;
      rom_rd    <= 1'b0;
      ram_wr    <= 1'b0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      rom_addr  <= SRC_BASE;
      ram_addr  <= DST_BASE;
      ram_wdata <= 12'd0;
      start_pc  <= START_PC;
`ifdef BOOTCOPY_CHECKSUM_EN
      err       <= 1'b0;
      sum       <= 12'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (COUNT == 8'd0) begin
            state <= FINISH;
          end else begin
            state    <= READ;
            rom_rd   <= 1'b1;
            rom_addr <= SRC_BASE;
          end
        end
        READ: begin
          rom_rd    <= 1'b0;
          ram_wdata <= rom_data;
          ram_addr  <= DST_BASE + {7'd0, idx};
          ram_wr    <= 1'b1;
          state     <= WRITE;
`ifdef BOOTCOPY_CHECKSUM_EN
          sum       <= sum + rom_data;
`endif
        end
        WRITE: begin
          // Address and data stay put until the RAM side accepts the word.
          if (ram_ack) begin
            ram_wr <= 1'b0;
            idx    <= idx_next;
            if (idx_next == COUNT) begin
              state <= FINISH;
            end else begin
              state    <= READ;
              rom_rd   <= 1'b1;
              rom_addr <= SRC_BASE + {7'd0, idx_next};
            end
          end
        end
        FINISH: begin
          done  <= 1'b1;
          state <= DONE;
`ifdef BOOTCOPY_CHECKSUM_EN
          // A bad image keeps the CPU stalled rather than booting garbage.
          if (sum == CHECKSUM) cpu_hold <= 1'b0;
          else                 err      <= 1'b1;
`else
          cpu_hold <= 1'b0;
`endif
        end
        DONE: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_copy_ctl.sv
// tb/tb_boot_copy_ctl.sv - directed bench for boot_copy_ctl: ack delays, COUNT=0, address wrap, reset abort
module tb_boot_copy_ctl;

  function automatic logic [11:0] calc_sum();
    logic [11:0] s;
    logic [14:0] a;
    s = 12'd0;
    for (int k = 0; k < 128; k++) begin
      a = 15'(15'o07400 + k);
      s = s + (a[11:0] ^ 12'o5252);
    end
    return s;
  endfunction

  localparam logic [11:0] CSUM = calc_sum();

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // dut0: default geometry, bench-driven ack
  logic [14:0] d0_rom_addr, d0_ram_addr;
  logic [11:0] d0_rom_data, d0_ram_wdata, d0_start_pc;
  logic        d0_rom_rd, d0_ram_wr, d0_cpu_hold, d0_done, d0_err;
  logic        ram_ack = 1'b0;
  assign d0_rom_data = d0_rom_addr[11:0] ^ 12'o5252;

  boot_copy_ctl #(.CHECKSUM(CSUM)) dut0 (
    .clk(clk), .reset(reset), .rom_addr(d0_rom_addr), .rom_rd(d0_rom_rd),
    .rom_data(d0_rom_data), .ram_addr(d0_ram_addr), .ram_wdata(d0_ram_wdata),
    .ram_wr(d0_ram_wr), .ram_ack(ram_ack), .cpu_hold(d0_cpu_hold),
    .start_pc(d0_start_pc), .done(d0_done), .err(d0_err));

  // dut1: COUNT=0
  logic [14:0] d1_rom_addr, d1_ram_addr;
  logic [11:0] d1_ram_wdata, d1_start_pc;
  logic        d1_rom_rd, d1_ram_wr, d1_cpu_hold, d1_done, d1_err;
  logic        d1_active = 1'b0;

  boot_copy_ctl #(.COUNT(8'd0)) dut1 (
    .clk(clk), .reset(reset), .rom_addr(d1_rom_addr), .rom_rd(d1_rom_rd),
    .rom_data(d1_rom_addr[11:0]), .ram_addr(d1_ram_addr), .ram_wdata(d1_ram_wdata),
    .ram_wr(d1_ram_wr), .ram_ack(1'b1), .cpu_hold(d1_cpu_hold),
    .start_pc(d1_start_pc), .done(d1_done), .err(d1_err));

  always @(negedge clk) if (d1_rom_rd || d1_ram_wr) d1_active <= 1'b1;

  // dut2: destination wraps past 77777
  logic [14:0] d2_rom_addr, d2_ram_addr;
  logic [11:0] d2_ram_wdata, d2_start_pc;
  logic        d2_rom_rd, d2_ram_wr, d2_cpu_hold, d2_done, d2_err;
  logic [14:0] d2_q[$];

  boot_copy_ctl #(.DST_BASE(15'o77776), .COUNT(8'd4)) dut2 (
    .clk(clk), .reset(reset), .rom_addr(d2_rom_addr), .rom_rd(d2_rom_rd),
    .rom_data(d2_rom_addr[11:0]), .ram_addr(d2_ram_addr), .ram_wdata(d2_ram_wdata),
    .ram_wr(d2_ram_wr), .ram_ack(1'b1), .cpu_hold(d2_cpu_hold),
    .start_pc(d2_start_pc), .done(d2_done), .err(d2_err));

  always @(negedge clk) begin
    if (reset) d2_q.delete();
    else if (d2_ram_wr) d2_q.push_back(d2_ram_addr);
  end

`ifdef BOOTCOPY_CHECKSUM_EN
  // dut4: expected checksum off by one
  logic [14:0] d4_rom_addr, d4_ram_addr;
  logic [11:0] d4_ram_wdata, d4_start_pc;
  logic        d4_rom_rd, d4_ram_wr, d4_cpu_hold, d4_done, d4_err;

  boot_copy_ctl #(.CHECKSUM(CSUM + 12'd1)) dut4 (
    .clk(clk), .reset(reset), .rom_addr(d4_rom_addr), .rom_rd(d4_rom_rd),
    .rom_data(d4_rom_addr[11:0] ^ 12'o5252), .ram_addr(d4_ram_addr), .ram_wdata(d4_ram_wdata),
    .ram_wr(d4_ram_wr), .ram_ack(1'b1), .cpu_hold(d4_cpu_hold),
    .start_pc(d4_start_pc), .done(d4_done), .err(d4_err));
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  // Runs one copy on dut0 from reset; ack arrives after `delay` extra WRITE cycles.
  task automatic run_copy(input int delay, input logic junk_ack, input int abort_at,
                          input logic side, output int cycles, output int nwr, output int bad);
    int          wcnt;
    logic [14:0] a0, ea;
    logic [11:0] d0;
    wcnt = 0; nwr = 0; cycles = 0; bad = 0;
    a0 = '0; d0 = '0;
    ram_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    check("reset cpu_hold", d0_cpu_hold, 1);
    check("reset done", d0_done, 0);
    check("reset strobes", {d0_rom_rd, d0_ram_wr}, 0);
    check("reset rom_addr", d0_rom_addr, 15'o07400);
    check("reset ram_addr", d0_ram_addr, 15'o07400);
    check("reset start_pc", d0_start_pc, 12'o7400);
    reset = 1'b0;
    ram_ack = junk_ack;
    while (cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (d0_rom_rd && d0_ram_wr) bad++;
      if (side && cycles == 1) check("count0 hold at 1", d1_cpu_hold, 1);
      if (side && cycles == 2) check("count0 release at 2", {d1_cpu_hold, d1_done}, 2'b01);
      if (!d0_cpu_hold) break;
      if (d0_ram_wr) begin
        if (abort_at >= 0 && nwr == abort_at) begin
          reset = 1'b1;
          ram_ack = 1'b0;
          @(negedge clk);
          check("abort ram_wr", d0_ram_wr, 0);
          check("abort hold/done", {d0_cpu_hold, d0_done}, 2'b10);
          check("abort rom_addr", d0_rom_addr, 15'o07400);
          return;
        end
        if (wcnt == 0) begin
          a0 = d0_ram_addr; d0 = d0_ram_wdata;
        end else if (d0_ram_addr != a0 || d0_ram_wdata != d0) begin
          bad++;
        end
        wcnt++;
        ram_ack = (wcnt > delay);
        if (ram_ack) begin
          ea = 15'(15'o07400 + nwr);
          if (d0_ram_addr != ea || d0_ram_wdata != (ea[11:0] ^ 12'o5252)) bad++;
          nwr++;
          wcnt = 0;
        end
      end else begin
        ram_ack = junk_ack;
        wcnt = 0;
      end
    end
    ram_ack = 1'b0;
  endtask

  typedef struct {
    int   delay;
    logic junk_ack;
    int   exp_cycles;
  } vec_t;

  vec_t vecs[4];
  int cyc, nwr, bad;

  initial begin
    vecs[0] = '{0, 1'b0, 258};
    vecs[1] = '{3, 1'b0, 2 + 5 * 128};
    vecs[2] = '{1, 1'b1, 2 + 3 * 128};
    vecs[3] = '{2, 1'b1, 2 + 4 * 128};

    for (int i = 0; i < 4; i++) begin
      run_copy(vecs[i].delay, vecs[i].junk_ack, -1, i == 0, cyc, nwr, bad);
      check($sformatf("v%0d release cycle", i), cyc, vecs[i].exp_cycles);
      check($sformatf("v%0d writes", i), nwr, 128);
      check($sformatf("v%0d addr/data/stability errors", i), bad, 0);
      check($sformatf("v%0d done/err", i), {d0_done, d0_err}, 2'b10);
      check($sformatf("v%0d start_pc", i), d0_start_pc, 12'o7400);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d idle strobes", i), {d0_rom_rd, d0_ram_wr, d0_cpu_hold}, 0);
      if (i == 0) begin
        check("wrap write count", d2_q.size(), 4);
        if (d2_q.size() == 4) begin
          check("wrap addr0", d2_q[0], 15'o77776);
          check("wrap addr1", d2_q[1], 15'o77777);
          check("wrap addr2", d2_q[2], 15'o00000);
          check("wrap addr3", d2_q[3], 15'o00001);
        end
        check("wrap done", {d2_done, d2_cpu_hold}, 2'b10);
`ifdef BOOTCOPY_CHECKSUM_EN
        check("bad checksum err/done/hold", {d4_err, d4_done, d4_cpu_hold}, 3'b111);
`endif
      end
    end

    run_copy(0, 1'b0, 10, 1'b0, cyc, nwr, bad);
    check("abort writes before reset", nwr, 10);
    run_copy(0, 1'b0, -1, 1'b0, cyc, nwr, bad);
    check("restart release cycle", cyc, 258);
    check("restart writes", nwr, 128);
    check("restart addr/data errors", bad, 0);

    check("count0 never active", d1_active, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
